// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master round-robin AXI write arbiter onto one slave
//
// Ports:
//   aclk, areset                   clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*                per-master AXI write channels, packed {m1,m0}
//   s_aw*/s_w*/s_b*                shared slave AXI write channels
//   grant_id                       owner of the current (or last) transaction
//   busy                           high while a transaction is in flight
//   len_err                        one-cycle pulse on burst length mismatch
//
// Optional feature macro: AXI_WR_ARB_LEN_CHECK_EN
//   defined   : s_wlast is generated from a beat counter against the latched
//               awlen, and len_err flags a disagreeing master wlast.
//   undefined : s_wlast is the granted master's wlast, len_err is 0.

module axi_wr_arbiter #(
    parameter  int ADDR_WID = 32,
    parameter  int DATA_WID = 32,
    localparam int STRB_WID = DATA_WID / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [2*ADDR_WID-1:0] m_awaddr,
    input  logic [15:0]           m_awlen,
    input  logic [1:0]            m_awvalid,
    output logic [1:0]            m_awready,
    input  logic [2*DATA_WID-1:0] m_wdata,
    input  logic [2*STRB_WID-1:0] m_wstrb,
    input  logic [1:0]            m_wlast,
    input  logic [1:0]            m_wvalid,
    output logic [1:0]            m_wready,
    output logic [3:0]            m_bresp,
    output logic [1:0]            m_bvalid,
    input  logic [1:0]            m_bready,
    output logic [ADDR_WID-1:0]   s_awaddr,
    output logic [7:0]            s_awlen,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_WID-1:0]   s_wdata,
    output logic [STRB_WID-1:0]   s_wstrb,
    output logic                  s_wlast,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   r_last_grant;

    logic [ADDR_WID-1:0] w_sel_awaddr;
    logic [7:0]          w_sel_awlen;
    logic                w_sel_awvalid;
    logic [DATA_WID-1:0] w_sel_wdata;
    logic [STRB_WID-1:0] w_sel_wstrb;
    logic                w_sel_wlast;
    logic                w_sel_wvalid;
    logic                w_sel_bready;
    logic                w_fwd_last;
    logic                w_pick;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;

    // Payload of whichever master currently owns the slave.
    assign w_sel_awaddr  = r_grant ? m_awaddr[2*ADDR_WID-1:ADDR_WID] : m_awaddr[ADDR_WID-1:0];
    assign w_sel_awlen   = r_grant ? m_awlen[15:8] : m_awlen[7:0];
    assign w_sel_awvalid = r_grant ? m_awvalid[1] : m_awvalid[0];
    assign w_sel_wdata   = r_grant ? m_wdata[2*DATA_WID-1:DATA_WID] : m_wdata[DATA_WID-1:0];
    assign w_sel_wstrb   = r_grant ? m_wstrb[2*STRB_WID-1:STRB_WID] : m_wstrb[STRB_WID-1:0];
    assign w_sel_wlast   = r_grant ? m_wlast[1] : m_wlast[0];
    assign w_sel_wvalid  = r_grant ? m_wvalid[1] : m_wvalid[0];
    assign w_sel_bready  = r_grant ? m_bready[1] : m_bready[0];

    // A lone requester wins; on a tie the master that was not served last wins.
    assign w_pick = (m_awvalid == 2'b11) ? ~r_last_grant : m_awvalid[1];

    // Handshakes are qualified by state so they never depend on the muxed outputs.
    assign w_aw_hs = (r_state == S_ADDR) & w_sel_awvalid & s_awready;
    assign w_w_hs  = (r_state == S_DATA) & w_sel_wvalid  & s_wready;
    assign w_b_hs  = (r_state == S_RESP) & s_bvalid      & w_sel_bready;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [7:0] r_awlen;
    logic [7:0] r_beat_cnt;
    logic       r_len_err;
    logic       w_gen_last;

    assign w_gen_last = (r_beat_cnt == r_awlen);
    assign w_fwd_last = w_gen_last;
    assign len_err    = r_len_err;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awlen    <= 8'd0;
            r_beat_cnt <= 8'd0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= w_w_hs & (w_sel_wlast != w_gen_last);
            if (w_aw_hs) begin
                r_awlen    <= w_sel_awlen;
                r_beat_cnt <= 8'd0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end
`else
    assign w_fwd_last = w_sel_wlast;
    assign len_err    = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && (|m_awvalid)) begin
                r_grant <= w_pick;
            end
            if (w_b_hs) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_awready   = 2'b00;
        m_wready    = 2'b00;
        m_bresp     = 4'b0000;
        m_bvalid    = 2'b00;
        s_awaddr    = '0;
        s_awlen     = 8'd0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wlast     = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|m_awvalid) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                s_awaddr  = w_sel_awaddr;
                s_awlen   = w_sel_awlen;
                s_awvalid = w_sel_awvalid;
                m_awready = r_grant ? {s_awready, 1'b0} : {1'b0, s_awready};
                if (w_aw_hs) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                s_wdata  = w_sel_wdata;
                s_wstrb  = w_sel_wstrb;
                s_wlast  = w_fwd_last;
                s_wvalid = w_sel_wvalid;
                m_wready = r_grant ? {s_wready, 1'b0} : {1'b0, s_wready};
                if (w_w_hs && w_fwd_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                m_bresp  = r_grant ? {s_bresp, 2'b00} : {2'b00, s_bresp};
                m_bvalid = r_grant ? {s_bvalid, 1'b0} : {1'b0, s_bvalid};
                s_bready = w_sel_bready;
                if (w_b_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule
